// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file write-back path.
// Used by regfile_write_arbiter and wb_fifo.
package regfile_wb_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO: power-of-2 depth, extra pointer bit
// tells full from empty.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  wb_req_t req_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Payload storage needs no reset; pointers gate validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= req_i;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write port arbiter: ALU vs buffered loads, plus a
// pending-load scoreboard. Optional WB_FORWARD_EN adds fwd outputs.
module regfile_write_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int LD_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [REG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [REG_W-1:0] ld_rd,
  input  logic [XLEN-1:0]  ld_data,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [REG_W-1:0] rs1_addr,
  input  logic [REG_W-1:0] rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
`ifdef WB_FORWARD_EN
  output logic             rs1_fwd,
  output logic             rs2_fwd,
`endif
  output logic             write_enable,
  output logic [REG_W-1:0] addr_rd,
  output logic [XLEN-1:0]  data_rd
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  wb_req_t          head;
  wb_req_t          ld_req;
  logic             full, empty;
  logic             force_ld;
  logic             alu_grant, fifo_grant;
  logic             push;

  logic [SW-1:0]    starve_q, starve_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic             we_q, we_d;
  logic [REG_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]  data_q, data_d;

  assign ld_req = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .req_i  (ld_req),
    .pop_i  (fifo_grant),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  // ALU has priority until the queue has waited STARVE_LIMIT grants.
  assign force_ld   = (starve_q == LIMIT) && !empty;
  assign alu_ready  = !force_ld;
  assign alu_grant  = alu_valid && alu_ready;
  assign fifo_grant = !empty && !alu_grant;
  assign ld_ready   = !full;
  assign push       = ld_valid && ld_ready;

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    unique case (1'b1)
      alu_grant: begin
        we_d   = (alu_rd != '0);
        addr_d = alu_rd;
        data_d = alu_data;
      end
      fifo_grant: begin
        we_d   = (head.rd != '0);
        addr_d = head.rd;
        data_d = head.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || fifo_grant)
      starve_d = '0;
    else if (alu_grant && starve_q != LIMIT)
      starve_d = starve_q + SW'(1);
  end

  // A new issue to the same rd outranks the clear.
  always_comb begin
    pend_d = pend_q;
    if (fifo_grant)  pend_d[head.rd]  = 1'b0;
    if (issue_valid) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      starve_q <= starve_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign write_enable = we_q;
  assign addr_rd      = addr_q;
  assign data_rd      = data_q;

`ifdef WB_FORWARD_EN
  logic ldw_q;
  logic rs1_hit, rs2_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ldw_q <= 1'b0;
    else     ldw_q <= fifo_grant;
  end

  assign rs1_hit  = we_q && (addr_q == rs1_addr);
  assign rs2_hit  = we_q && (addr_q == rs2_addr);
  assign rs1_busy = pend_q[rs1_addr] && !(rs1_hit && ldw_q);
  assign rs2_busy = pend_q[rs2_addr] && !(rs2_hit && ldw_q);
  assign rs1_fwd  = rs1_hit && (rs1_addr != '0);
  assign rs2_fwd  = rs2_hit && (rs2_addr != '0);
`else
  assign rs1_busy = pend_q[rs1_addr];
  assign rs2_busy = pend_q[rs2_addr];
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, directed
// corner sequences and random traffic against a queue model.
module tb_regfile_write_arbiter;

  localparam int LD_DEPTH     = 4;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid, ld_valid, issue_valid;
  logic [4:0]  alu_rd, ld_rd, issue_rd, rs1_addr, rs2_addr;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, rs1_busy, rs2_busy;
  logic        write_enable;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
`ifdef WB_FORWARD_EN
  logic        rs1_fwd, rs2_fwd;
`endif

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .LD_DEPTH    (LD_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
`ifdef WB_FORWARD_EN
    .rs1_fwd     (rs1_fwd),
    .rs2_fwd     (rs2_fwd),
`endif
    .write_enable(write_enable),
    .addr_rd     (addr_rd),
    .data_rd     (data_rd)
  );

  int nvec = 0;
  int nerr = 0;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endfunction

  // Reference model: a queue of pending loads and a busy bit set.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  bit [31:0]   m_pend;
  logic        m_we, m_ldw;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic void m_reset();
    mq.delete();
    m_starve = 0;
    m_pend   = '0;
    m_we     = 1'b0;
    m_ldw    = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endfunction

  function automatic bit m_force();
    return (m_starve == STARVE_LIMIT) && (mq.size() != 0);
  endfunction

  function automatic bit m_busy(logic [4:0] rs);
    bit b;
    b = m_pend[rs];
`ifdef WB_FORWARD_EN
    if (m_we && m_addr == rs && m_ldw) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic void m_step();
    bit   ag, fg, was_empty, can_push;
    ent_t h, e;
    was_empty = (mq.size() == 0);
    can_push  = (mq.size() < LD_DEPTH);
    ag = alu_valid && !m_force();
    fg = !was_empty && !ag;
    m_ldw = fg;
    if (ag) begin
      m_we   = (alu_rd != 0);
      m_addr = alu_rd;
      m_data = alu_data;
    end else if (fg) begin
      h = mq.pop_front();
      m_we   = (h.rd != 0);
      m_addr = h.rd;
      m_data = h.data;
      m_pend[h.rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (ld_valid && can_push) begin
      e.rd   = ld_rd;
      e.data = ld_data;
      mq.push_back(e);
    end
    if (was_empty || fg) m_starve = 0;
    else if (ag && m_starve < STARVE_LIMIT) m_starve++;
    if (issue_valid) m_pend[issue_rd] = 1'b1;
    m_pend[0] = 1'b0;
  endfunction

  task automatic cmp_model(string t);
    chk({t, ".alu_ready"}, alu_ready, !m_force());
    chk({t, ".ld_ready"}, ld_ready, mq.size() < LD_DEPTH);
    chk({t, ".rs1_busy"}, rs1_busy, m_busy(rs1_addr));
    chk({t, ".rs2_busy"}, rs2_busy, m_busy(rs2_addr));
    chk({t, ".we"}, write_enable, m_we);
    chk({t, ".addr"}, addr_rd, m_addr);
    chk({t, ".data"}, data_rd, m_data);
`ifdef WB_FORWARD_EN
    chk({t, ".fwd1"}, rs1_fwd,
        m_we && m_addr == rs1_addr && rs1_addr != 0);
    chk({t, ".fwd2"}, rs2_fwd,
        m_we && m_addr == rs2_addr && rs2_addr != 0);
`endif
  endtask

  // One cycle: check at negedge, step the model on the edge.
  task automatic cyc(string t);
    @(negedge clk);
    cmp_model(t);
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  typedef struct {
    logic [31:0] av, ard, adata, lv, lrd, ldata, iv, ird, rs1;
    logic [31:0] e_ar, e_lr, e_b1, e_we, e_addr, e_data;
  } vec_t;

  vec_t tbl[12];
  int   got[$];

  initial begin
    // Load-only path, then ALU priority with forced load.
    tbl[0]  = '{0,0,0, 0,0,0, 1,7, 7, 1,1,0, 0,0,0};
    tbl[1]  = '{0,0,0, 1,7,32'hDEADBEEF, 0,0, 7, 1,1,1, 0,0,0};
    tbl[2]  = '{0,0,0, 0,0,0, 0,0, 7, 1,1,1, 0,0,0};
    tbl[3]  = '{0,0,0, 0,0,0, 0,0, 7,
                1,1,0, 1,7,32'hDEADBEEF};
    tbl[4]  = '{1,1,32'hA1, 1,3,32'h33, 0,0, 7,
                1,1,0, 0,7,32'hDEADBEEF};
    tbl[5]  = '{1,2,32'hA2, 0,0,0, 0,0, 7, 1,1,0, 1,1,32'hA1};
    tbl[6]  = '{1,4,32'hA4, 0,0,0, 0,0, 7, 1,1,0, 1,2,32'hA2};
    tbl[7]  = '{1,5,32'hA5, 0,0,0, 0,0, 7, 1,1,0, 1,4,32'hA4};
    tbl[8]  = '{1,6,32'hA6, 0,0,0, 0,0, 7, 0,1,0, 1,5,32'hA5};
    tbl[9]  = '{1,6,32'hA6, 0,0,0, 0,0, 7, 1,1,0, 1,3,32'h33};
    tbl[10] = '{0,0,0, 0,0,0, 0,0, 7, 1,1,0, 1,6,32'hA6};
    tbl[11] = '{0,0,0, 0,0,0, 0,0, 7, 1,1,0, 0,6,32'hA6};

    idle();
    rs1_addr = '0;
    rs2_addr = '0;
    m_reset();

    #2 rst = 1'b1;
    #1;
    chk("reset.we", write_enable, 0);
    chk("reset.addr", addr_rd, 0);
    chk("reset.data", data_rd, 0);
    chk("reset.ld_ready", ld_ready, 1);
    chk("reset.alu_ready", alu_ready, 1);
    chk("reset.rs1_busy", rs1_busy, 0);
    chk("reset.rs2_busy", rs2_busy, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    m_step();
    #1;

    for (int i = 0; i < 12; i++) begin
      alu_valid   = tbl[i].av[0];
      alu_rd      = tbl[i].ard[4:0];
      alu_data    = tbl[i].adata;
      ld_valid    = tbl[i].lv[0];
      ld_rd       = tbl[i].lrd[4:0];
      ld_data     = tbl[i].ldata;
      issue_valid = tbl[i].iv[0];
      issue_rd    = tbl[i].ird[4:0];
      rs1_addr    = tbl[i].rs1[4:0];
      @(negedge clk);
      chk($sformatf("tbl%0d.alu_ready", i), alu_ready, tbl[i].e_ar);
      chk($sformatf("tbl%0d.ld_ready", i), ld_ready, tbl[i].e_lr);
      chk($sformatf("tbl%0d.rs1_busy", i), rs1_busy, tbl[i].e_b1);
      chk($sformatf("tbl%0d.we", i), write_enable, tbl[i].e_we);
      chk($sformatf("tbl%0d.addr", i), addr_rd, tbl[i].e_addr);
      chk($sformatf("tbl%0d.data", i), data_rd, tbl[i].e_data);
      @(posedge clk);
      m_step();
      #1;
    end

    // Reset mid-stream with two queued loads and rd=5 pending.
    idle();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1010;
    ld_valid  = 1'b1; ld_rd  = 5'd11; ld_data  = 32'h1111;
    cyc("rst.a");
    ld_rd = 5'd12; ld_data = 32'h1212;
    issue_valid = 1'b1; issue_rd = 5'd5;
    cyc("rst.b");
    idle();
    rs1_addr = 5'd5;
    #2;
    chk("rst.pre_busy", rs1_busy, 1);
    chk("rst.pre_ld_ready", ld_ready, 1);
    rst = 1'b1;
    #1;
    chk("rst.we", write_enable, 0);
    chk("rst.ld_ready", ld_ready, 1);
    chk("rst.rs1_busy", rs1_busy, 0);
    chk("rst.addr", addr_rd, 0);
    m_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    m_step();
    #1;
    cyc("rst.after");

    // FIFO full with ALU traffic held high.
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(k + 1);
      alu_data  = 32'hA0 + k;
      ld_valid  = 1'b1;
      ld_rd     = 5'(20 + k);
      ld_data   = 32'hB0 + k;
      cyc($sformatf("full.push%0d", k));
    end
    ld_valid = 1'b0;
    alu_rd   = 5'd30;
    @(negedge clk);
    chk("full.ld_ready", ld_ready, 0);
    chk("full.alu_ready", alu_ready, 0);
    cmp_model("full.force");
    @(posedge clk);
    m_step();
    #1;
    chk("full.ld_ready_back", ld_ready, 1);
    alu_valid = 1'b0;
    if (write_enable) got.push_back(int'(addr_rd));
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("full.drain%0d", k));
      if (write_enable) got.push_back(int'(addr_rd));
    end
    chk("full.count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk($sformatf("full.order%0d", k), got[k], 20 + k);

    // x0 writes are discarded; x0 never becomes busy.
    idle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs1_addr = 5'd0;
    cyc("x0.alu");
    idle();
    chk("x0.alu_we", write_enable, 0);
    chk("x0.alu_data", data_rd, 32'h1234);
    chk("x0.busy", rs1_busy, 0);
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
    cyc("x0.push");
    idle();
    cyc("x0.pop");
    chk("x0.ld_we", write_enable, 0);
    chk("x0.ld_data", data_rd, 32'h55);

    // Pop of rd=9 coincides with a fresh issue to rd=9.
    idle();
    rs1_addr = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd9;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    cyc("setclr.a");
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    cyc("setclr.b");
    idle();
    chk("setclr.we", write_enable, 1);
    chk("setclr.addr", addr_rd, 9);
    cyc("setclr.c");
    chk("setclr.busy", rs1_busy, 1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      alu_valid   = ($urandom_range(0, 9) < 6);
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      ld_valid    = ($urandom_range(0, 1) == 1);
      ld_rd       = 5'($urandom_range(0, 7));
      ld_data     = $urandom;
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rd    = 5'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      cyc("rnd");
    end
    idle();
    cyc("end");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
